// File: rtl/scrolling_window_controller.sv
// ============================================================================
// Module   : scrolling_window_controller
// Purpose  : Scrolls a packed, right-aligned ASCII string (up to NUM_CHARS
//            chars) through a WIN_CHARS-wide window that feeds a packed-ASCII
//            7-segment driver. It supports one-shot and wrap modes, a
//            load/busy/done handshake and a dwell time per scroll step.
// Ports    : clk      - clock, rising edge
//            reset    - synchronous, active-high
//            str_in   - packed string; char 0 (rightmost) sits in the LSBs
//            str_len  - valid chars, counted from the right (clamped)
//            mode     - 0 = one-shot, 1 = wrap
//            load     - 1-cycle request to latch str_in/str_len/mode
//            pause    - freeze scrolling (only with SCROLL_PAUSE_EN)
//            window   - registered window; leftmost visible char in MSBs
//            busy     - high while a scroll is running
//            step     - 1-cycle pulse on every window shift
//            done     - 1-cycle pulse when a one-shot/static display completes
// Config   : `define SCROLL_PAUSE_EN adds the pause port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scrolling_window_controller #(
  parameter int NUM_CHARS    = 10,
  parameter int WIN_CHARS    = 4,
  parameter int CHAR_BITS    = 8,
  parameter logic [CHAR_BITS-1:0] BLANK_CHAR = '0,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26,
  parameter int LEN_W        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CHARS*CHAR_BITS-1:0] str_in,
  input  logic [LEN_W-1:0]               str_len,
  input  logic                           mode,
  input  logic                           load,
`ifdef SCROLL_PAUSE_EN
  input  logic                           pause,
`endif
  output logic [WIN_CHARS*CHAR_BITS-1:0] window,
  output logic                           busy,
  output logic                           step,
  output logic                           done
);

  localparam int SW = NUM_CHARS * CHAR_BITS;
  localparam int WW = WIN_CHARS * CHAR_BITS;
  // One extra bit so ptr + slot offset never overflows before the modulo.
  localparam int PW = LEN_W + 1;
  localparam logic [LEN_W-1:0] C_NUM_LEN  = LEN_W'(NUM_CHARS);
  localparam logic [CNT_W-1:0] C_DWELL_TC = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    SCROLL = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q,  state_d;
  logic [SW-1:0]     str_q,    str_d;
  logic [PW-1:0]     len_q,    len_d;
  logic              mode_q,   mode_d;
  logic [PW-1:0]     ptr_q,    ptr_d;
  logic [CNT_W-1:0]  dwell_q,  dwell_d;
  logic [WW-1:0]     window_q, window_d;
  logic              busy_q,   busy_d;
  logic              step_q,   step_d;
  logic              done_q,   done_d;

  logic              pause_active;
  logic [LEN_W-1:0]  len_clamped;
  logic [PW-1:0]     ptr_next;

`ifdef SCROLL_PAUSE_EN
  assign pause_active = pause;
`else
  assign pause_active = 1'b0;
`endif

  assign len_clamped = (str_len > C_NUM_LEN) ? C_NUM_LEN : str_len;

  // Char at absolute position pos (0 = rightmost) of the latched string.
  function automatic logic [CHAR_BITS-1:0] char_at(input logic [SW-1:0] s,
                                                   input logic [PW-1:0] pos);
    logic [CHAR_BITS-1:0] c;
    c = BLANK_CHAR;
    for (int j = 0; j < NUM_CHARS; j++) begin
      if (pos == PW'(j)) c = s[j*CHAR_BITS +: CHAR_BITS];
    end
    return c;
  endfunction

  // Scrolling view: slot k shows seq[(ptr+k) mod (len+1)], where seq is the
  // string read leftmost-first followed by a single blank gap. ptr <= len and
  // k < len, so one conditional subtract implements the modulo.
  function automatic logic [WW-1:0] scroll_window(input logic [SW-1:0] s,
                                                  input logic [PW-1:0] len,
                                                  input logic [PW-1:0] ptr);
    logic [WW-1:0] w;
    logic [PW-1:0] idx;
    w = '0;
    for (int k = 0; k < WIN_CHARS; k++) begin
      idx = ptr + PW'(k);
      if (idx > len) idx = idx - (len + PW'(1));
      if (idx == len) w[(WIN_CHARS-1-k)*CHAR_BITS +: CHAR_BITS] = BLANK_CHAR;
      else            w[(WIN_CHARS-1-k)*CHAR_BITS +: CHAR_BITS] =
                        char_at(s, len - PW'(1) - idx);
    end
    return w;
  endfunction

  // Static view for short strings: right-justified, blank-padded on the left.
  function automatic logic [WW-1:0] static_window(input logic [SW-1:0] s,
                                                  input logic [PW-1:0] len);
    logic [WW-1:0] w;
    logic [PW-1:0] pos;
    w = '0;
    for (int k = 0; k < WIN_CHARS; k++) begin
      pos = PW'(WIN_CHARS - 1 - k);
      w[(WIN_CHARS-1-k)*CHAR_BITS +: CHAR_BITS] =
        (pos < len) ? char_at(s, pos) : BLANK_CHAR;
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      str_q    <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      ptr_q    <= '0;
      dwell_q  <= '0;
      window_q <= {WIN_CHARS{BLANK_CHAR}};
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      str_q    <= str_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      ptr_q    <= ptr_d;
      dwell_q  <= dwell_d;
      window_q <= window_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    str_d    = str_q;
    len_d    = len_q;
    mode_d   = mode_q;
    ptr_d    = ptr_q;
    dwell_d  = dwell_q;
    window_d = window_q;
    busy_d   = 1'b0;
    step_d   = 1'b0;
    done_d   = 1'b0;
    ptr_next = ptr_q + PW'(1);

    case (state_q)
      START: begin
        if (len_q <= PW'(WIN_CHARS)) begin
          // Covers len == 0 as well: every slot falls in the blank padding.
          window_d = static_window(str_q, len_q);
          done_d   = 1'b1;
          state_d  = HOLD;
        end else begin
          ptr_d    = '0;
          dwell_d  = '0;
          window_d = scroll_window(str_q, len_q, '0);
          busy_d   = 1'b1;
          state_d  = SCROLL;
        end
      end
      SCROLL: begin
        // busy stays high through the final step cycle and drops one later.
        busy_d = 1'b1;
        if (!pause_active) begin
          if (dwell_q == C_DWELL_TC) begin
            if (mode_q && (ptr_q == len_q)) ptr_next = '0;
            dwell_d  = '0;
            step_d   = 1'b1;
            ptr_d    = ptr_next;
            window_d = scroll_window(str_q, len_q, ptr_next);
            if (!mode_q && (ptr_next == len_q - PW'(WIN_CHARS))) begin
              done_d  = 1'b1;
              state_d = HOLD;
            end
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
      end
      default: ;  // IDLE and HOLD keep the window frozen with busy low.
    endcase

    // A new load aborts whatever was in progress, including a pause.
    if (load) begin
      str_d   = str_in;
      len_d   = {1'b0, len_clamped};
      mode_d  = mode;
      ptr_d   = '0;
      dwell_d = '0;
      busy_d  = 1'b0;
      step_d  = 1'b0;
      done_d  = 1'b0;
      state_d = START;
    end
  end

  assign window = window_q;
  assign busy   = busy_q;
  assign step   = step_q;
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_scrolling_window_controller.sv
// ============================================================================
// Module   : tb_scrolling_window_controller
// Purpose  : Self-checking bench for scrolling_window_controller. Expected
//            windows come from the string viewed as a periodic sequence
//            (chars followed by one blank) indexed by elapsed time / dwell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scrolling_window_controller;

  localparam int NC = 10;
  localparam int W  = 4;
  localparam int CB = 8;
  localparam int D  = 4;
  localparam int SW = NC * CB;
  localparam int WW = W * CB;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] str_in;
  logic [3:0]    str_len;
  logic          mode;
  logic          load;
`ifdef SCROLL_PAUSE_EN
  logic          pause;
`endif
  logic [WW-1:0] window;
  logic          busy, step, done;

  int n_checks = 0;
  int n_pass   = 0;

  scrolling_window_controller #(
    .NUM_CHARS(NC), .WIN_CHARS(W), .CHAR_BITS(CB), .BLANK_CHAR(8'h00),
    .DWELL_CYCLES(D), .CNT_W(26), .LEN_W(4)
  ) dut (
    .clk(clk), .reset(reset), .str_in(str_in), .str_len(str_len),
    .mode(mode), .load(load),
`ifdef SCROLL_PAUSE_EN
    .pause(pause),
`endif
    .window(window), .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Right-aligned packing: last character of the text lands in char 0.
  function automatic logic [SW-1:0] pack(input string s);
    logic [SW-1:0] p;
    p = '0;
    for (int i = 0; i < s.len() && i < NC; i++)
      p[i*CB +: CB] = s[s.len() - 1 - i];
    return p;
  endfunction

  function automatic logic [SW-1:0] rand_str();
    logic [SW-1:0] p;
    for (int i = 0; i < NC; i++) p[i*CB +: CB] = 8'($urandom_range(8'h21, 8'h7e));
    return p;
  endfunction

  // seq[i] = i-th valid char reading left to right; seq[len] = blank gap.
  function automatic logic [CB-1:0] seq_at(input logic [SW-1:0] s, input int len, input int i);
    if (i == len) return 8'h00;
    return s[(len - 1 - i)*CB +: CB];
  endfunction

  function automatic logic [WW-1:0] exp_win(input logic [SW-1:0] s, input int len, input int p);
    logic [WW-1:0] w;
    for (int k = 0; k < W; k++)
      w[(W-1-k)*CB +: CB] = seq_at(s, len, (p + k) % (len + 1));
    return w;
  endfunction

  function automatic logic [WW-1:0] exp_static(input logic [SW-1:0] s, input int len);
    logic [WW-1:0] w;
    for (int k = 0; k < W; k++)
      w[(W-1-k)*CB +: CB] = ((W - 1 - k) < len) ? s[(W-1-k)*CB +: CB] : 8'h00;
    return w;
  endfunction

  // Loads a string, then checks every following cycle against the time model.
  // Inputs are scrambled after the load to show the string was latched.
  task automatic run_load(input string name, input logic [SW-1:0] s, input int slen,
                          input bit m, input int ncycles);
    int len, shifts, last, p;
    logic [WW-1:0] ew;
    logic es, ed, eb;
    len = (slen > NC) ? NC : slen;
    str_in = s; str_len = 4'(slen); mode = m; load = 1'b1;
    tick;
    load = 1'b0;
    n_checks++;
    if ({busy, step, done} !== 3'b000)
      $display("FAIL %s start-cycle flags: got busy/step/done=%b want 000", name, {busy, step, done});
    else n_pass++;
    for (int t = 0; t < ncycles; t++) begin
      str_in = rand_str(); str_len = 4'($urandom); mode = 1'($urandom);
      tick;
      if (len <= W) begin
        ew = exp_static(s, len); es = 1'b0; ed = (t == 0); eb = 1'b0;
      end else begin
        shifts = t / D;
        if (!m) begin
          last = len - W;
          p  = (shifts > last) ? last : shifts;
          es = (t > 0) && (t % D == 0) && (shifts <= last);
          ed = (t == D * last);
          eb = (t <= D * last);
        end else begin
          p  = shifts % (len + 1);
          es = (t > 0) && (t % D == 0);
          ed = 1'b0;
          eb = 1'b1;
        end
        ew = exp_win(s, len, p);
      end
      n_checks++;
      if (window !== ew)
        $display("FAIL %s t=%0d window: got %h want %h", name, t, window, ew);
      else n_pass++;
      n_checks++;
      if ({busy, step, done} !== {eb, es, ed})
        $display("FAIL %s t=%0d busy/step/done: got %b want %b", name, t,
                 {busy, step, done}, {eb, es, ed});
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++;
      if ({window, busy, step, done} !== '0)
        $display("FAIL reset_hold cycle %0d: got window=%h flags=%b want all 0", i,
                 window, {busy, step, done});
      else n_pass++;
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      n_checks++;
      if ({window, busy, step, done} !== '0)
        $display("FAIL reset_idle cycle %0d: got window=%h flags=%b want all 0", i,
                 window, {busy, step, done});
      else n_pass++;
    end
  endtask

  task automatic test_static;
    run_load("static_1234", pack("1234"), 4, 1'b0, 6);
    run_load("static_12", pack("12"), 2, 1'b0, 6);
    run_load("static_empty", pack("xyz"), 0, 1'b1, 4);
    for (int i = 0; i < 4; i++)
      run_load("static_rand", rand_str(), $urandom_range(0, W), 1'($urandom), 5);
  endtask

  task automatic test_oneshot;
    run_load("oneshot_1234567890", pack("1234567890"), 10, 1'b0, D * 6 + 5);
    for (int i = 0; i < 3; i++)
      run_load("oneshot_rand", rand_str(), $urandom_range(W + 1, NC), 1'b0, D * NC + 4);
  endtask

  task automatic test_wrap;
    run_load("wrap_12345", pack("12345"), 5, 1'b1, 40);
    for (int i = 0; i < 2; i++)
      run_load("wrap_rand", rand_str(), $urandom_range(W + 1, 15), 1'b1, D * (NC + 1) * 2);
  endtask

  task automatic test_abort;
    logic [SW-1:0] s;
    s = pack("ABCDE98765");
    run_load("abort_first", pack("12345"), 5, 1'b1, 7);
    run_load("abort_reload_len15", s, 15, 1'b0, D * 6 + 3);
    run_load("abort_pre_reset", pack("12345"), 5, 1'b1, 12);
    reset = 1'b1;
    tick;
    n_checks++;
    if ({window, busy, step, done} !== '0)
      $display("FAIL reset_midscroll: got window=%h flags=%b want all 0", window, {busy, step, done});
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++;
      if ({window, busy, step, done} !== '0)
        $display("FAIL reset_after cycle %0d: got window=%h flags=%b want all 0", i,
                 window, {busy, step, done});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    str_in = pack("ZYXWVUTS"); str_len = 4'd8; mode = 1'b1; load = 1'b1;
    tick;
    run_load("back_to_back", pack("QRSTUVW"), 7, 1'b0, D * 3 + 4);
  endtask

`ifdef SCROLL_PAUSE_EN
  task automatic test_pause;
    logic [SW-1:0] s;
    s = pack("1234567890");
    str_in = s; str_len = 4'd10; mode = 1'b0; load = 1'b1;
    tick;
    load = 1'b0;
    for (int i = 0; i < 3; i++) tick;  // dwell now at 2
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      n_checks++;
      if ({window, step, busy} !== {exp_win(s, 10, 0), 1'b0, 1'b1})
        $display("FAIL pause_frozen cycle %0d: got window=%h step=%b busy=%b want %h 0 1", i,
                 window, step, busy, exp_win(s, 10, 0));
      else n_pass++;
    end
    pause = 1'b0;
    tick;
    n_checks++;
    if (step !== 1'b0) $display("FAIL pause_resume_1: got step=%b want 0", step);
    else n_pass++;
    tick;
    n_checks++;
    if ({window, step} !== {exp_win(s, 10, 1), 1'b1})
      $display("FAIL pause_resume_2: got window=%h step=%b want %h 1", window, step,
               exp_win(s, 10, 1));
    else n_pass++;
  endtask
`endif

  initial begin
    reset = 1'b1; str_in = '0; str_len = '0; mode = 1'b0; load = 1'b0;
`ifdef SCROLL_PAUSE_EN
    pause = 1'b0;
`endif
    test_reset;
    test_static;
    test_oneshot;
    test_wrap;
    test_abort;
    test_back_to_back;
`ifdef SCROLL_PAUSE_EN
    test_pause;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
